// File: rtl/mer_meas_seq_pkg.sv
// Shared types and constants for the MER measurement sequencer.
// Holds the FSM encoding, default widths and saturation limits.
package meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 32;
  localparam int ERR_W     = 18;
  localparam int PER_W     = 4;

  // Wide all-ones pattern; accumulators slice it to their own width (W <= 64).
  localparam logic [63:0] SAT_ONES = '1;

  // A window of zero periods is run as a single period.
  function automatic logic [PER_W-1:0] per_init(input logic [PER_W-1:0] n);
    return (n == '0) ? PER_W'(1) : n;
  endfunction

endpackage

// File: rtl/mer_meas_seq_sat_accum.sv
// Saturating accumulator with clear and enable; signed or unsigned.
// Clear together with enable loads the addend as the first term.
module sat_accum
  import meas_pkg::*;
#(
  parameter int W         = ACC_W_DEF,
  parameter int IN_W      = ERR_W,
  parameter bit IS_SIGNED = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [IN_W-1:0] i_add,
  output logic [W-1:0]    o_acc
);

  localparam logic [W-1:0] MAX_U = SAT_ONES[W-1:0];
  localparam logic [W-1:0] MAX_S = MAX_U >> 1;
  localparam logic [W-1:0] MIN_S = ~MAX_S;

  logic [W-1:0] r_acc;
  logic [W:0]   w_add_ext;
  logic [W:0]   w_base;
  logic [W:0]   w_sum;
  logic         w_ovf;
  logic [W-1:0] w_sat;
  logic [W-1:0] w_nxt;

  // One guard bit keeps the sum exact, so overflow is read straight off the top bits.
  always_comb begin
    w_add_ext = IS_SIGNED ? {{(W+1-IN_W){i_add[IN_W-1]}}, i_add}
                          : {{(W+1-IN_W){1'b0}}, i_add};
    w_base    = i_clr ? '0 : {IS_SIGNED & r_acc[W-1], r_acc};
    w_sum     = w_base + w_add_ext;
    w_ovf     = IS_SIGNED ? (w_sum[W] ^ w_sum[W-1]) : w_sum[W];
    w_sat     = IS_SIGNED ? (w_sum[W] ? MIN_S : MAX_S) : MAX_U;
    w_nxt     = w_ovf ? w_sat : w_sum[W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_nxt;
    end else if (i_clr) begin
      r_acc <= '0;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mer_meas_seq.sv
// Measurement sequencer: aligns to the LFSR period marker, accumulates error
// statistics over whole periods, then publishes held results with a done pulse.
module mer_meas_seq
  import meas_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             sym_clk_en,
  input  logic             cycle_out_periodic,
  input  logic             start,
  input  logic [PER_W-1:0] num_periods,
  input  logic [ERR_W-1:0] err_sq,
  input  logic [ERR_W-1:0] err_dc,
  input  logic             rx_data_correct,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sq_acc,
  output logic [ACC_W-1:0] dc_acc,
  output logic [CNT_W-1:0] sym_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PER_W-1:0] r_per_left;
  logic             w_mark;
  logic             w_last;
  logic             w_acc_clr;
  logic             w_acc_en;
  logic             w_load;
  logic             w_per_init;
  logic             w_per_dec;

  logic [ACC_W-1:0] w_sq_work;
  logic [ACC_W-1:0] w_dc_work;
  logic [CNT_W-1:0] w_sym_work;
  logic [CNT_W-1:0] w_err_work;

  logic [ACC_W-1:0] r_sq_acc;
  logic [ACC_W-1:0] r_dc_acc;
  logic [CNT_W-1:0] r_sym_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_mark = sym_clk_en & cycle_out_periodic;
  assign w_last = (r_per_left == PER_W'(1));

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start)            w_state_nxt = ST_ARM;
      ST_ARM:  if (w_mark)           w_state_nxt = ST_MEAS;
      ST_MEAS: if (w_mark && w_last) w_state_nxt = ST_DONE;
      ST_DONE:                       w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  // The terminating marker symbol is not accumulated; it opens the next period.
  always_comb begin
    busy       = (r_state == ST_ARM) || (r_state == ST_MEAS);
    done       = (r_state == ST_DONE);
    w_acc_clr  = 1'b0;
    w_acc_en   = 1'b0;
    w_load     = 1'b0;
    w_per_init = 1'b0;
    w_per_dec  = 1'b0;
    unique case (r_state)
      ST_IDLE: w_per_init = start;
      ST_ARM: begin
        w_acc_clr = w_mark;
        w_acc_en  = w_mark;
      end
      ST_MEAS: begin
        if (w_mark && w_last) begin
          w_load = 1'b1;
        end else if (sym_clk_en) begin
          w_acc_en  = 1'b1;
          w_per_dec = cycle_out_periodic;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_per_left <= '0;
    end else if (w_per_init) begin
      r_per_left <= per_init(num_periods);
    end else if (w_per_dec) begin
      r_per_left <= r_per_left - PER_W'(1);
    end
  end

  sat_accum #(.W(ACC_W), .IN_W(ERR_W), .IS_SIGNED(1'b0)) u_sq (
    .i_clk(sys_clk), .i_reset(reset), .i_clr(w_acc_clr), .i_en(w_acc_en),
    .i_add(err_sq), .o_acc(w_sq_work)
  );

  sat_accum #(.W(ACC_W), .IN_W(ERR_W), .IS_SIGNED(1'b1)) u_dc (
    .i_clk(sys_clk), .i_reset(reset), .i_clr(w_acc_clr), .i_en(w_acc_en),
    .i_add(err_dc), .o_acc(w_dc_work)
  );

  sat_accum #(.W(CNT_W), .IN_W(1), .IS_SIGNED(1'b0)) u_sym (
    .i_clk(sys_clk), .i_reset(reset), .i_clr(w_acc_clr), .i_en(w_acc_en),
    .i_add(1'b1), .o_acc(w_sym_work)
  );

  sat_accum #(.W(CNT_W), .IN_W(1), .IS_SIGNED(1'b0)) u_err (
    .i_clk(sys_clk), .i_reset(reset), .i_clr(w_acc_clr), .i_en(w_acc_en),
    .i_add(~rx_data_correct), .o_acc(w_err_work)
  );

  // NOTE: result registers are reset explicitly so a mid-window reset clears the readout too.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_sq_acc  <= '0;
      r_dc_acc  <= '0;
      r_sym_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_load) begin
      r_sq_acc  <= w_sq_work;
      r_dc_acc  <= w_dc_work;
      r_sym_cnt <= w_sym_work;
      r_err_cnt <= w_err_work;
    end
  end

  assign sq_acc  = r_sq_acc;
  assign dc_acc  = r_dc_acc;
  assign sym_cnt = r_sym_cnt;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_mer_meas_seq.sv
// Self-checking bench for mer_meas_seq: a symbol generator with a 15-symbol
// LFSR period feeds the DUT, and a window model over the logged symbols predicts results.
module tb_mer_meas_seq;

  localparam int     ACC_W  = 20;
  localparam int     CNT_W  = 32;
  localparam int     PERIOD = 15;
  localparam longint SQ_MAX = (64'sd1 <<< ACC_W) - 1;
  localparam longint DC_MAX = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint DC_MIN = -(64'sd1 <<< (ACC_W - 1));
  localparam int     BUDGET = 3000;

  logic             sys_clk = 1'b0;
  logic             reset = 1'b1;
  logic             sym_clk_en = 1'b0;
  logic             cycle_out_periodic = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       num_periods = '0;
  logic [17:0]      err_sq = '0;
  logic [17:0]      err_dc = '0;
  logic             rx_data_correct = 1'b1;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] sq_acc;
  logic [ACC_W-1:0] dc_acc;
  logic [CNT_W-1:0] sym_cnt;
  logic [CNT_W-1:0] err_cnt;

  mer_meas_seq #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .reset(reset), .sym_clk_en(sym_clk_en),
    .cycle_out_periodic(cycle_out_periodic), .start(start), .num_periods(num_periods),
    .err_sq(err_sq), .err_dc(err_dc), .rx_data_correct(rx_data_correct),
    .busy(busy), .done(done), .sq_acc(sq_acc), .dc_acc(dc_acc),
    .sym_cnt(sym_cnt), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int     cyc;
    bit     mark;
    longint sq;
    longint dc;
    bit     ok;
    int     pos;
  } sym_t;

  typedef struct {
    longint sq;
    longint dc;
    longint sym;
    longint err;
    int     term_cyc;
  } exp_t;

  sym_t sym_log[$];
  int   cyc_n = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Generator controls: data_mode 0 = fixed values, 1 = random;
  // ok_mode 0 = fixed, 1 = four bad positions per period, 2 = random.
  int               data_mode = 0;
  int               ok_mode = 0;
  logic [17:0]      fx_sq = '0;
  logic signed [17:0] fx_dc = '0;
  bit               fx_ok = 1'b1;
  int               sym_pos = 0;
  int               cur_pos = 0;
  int               gap_left = 0;

  initial begin
    forever begin
      @(negedge sys_clk);
      if (gap_left > 0) begin
        gap_left--;
        sym_clk_en         = 1'b0;
        cycle_out_periodic = 1'($urandom_range(0, 1));
        err_sq             = 18'($urandom);
        err_dc             = 18'($urandom);
        rx_data_correct    = 1'($urandom_range(0, 1));
      end else begin
        sym_clk_en         = 1'b1;
        cycle_out_periodic = (sym_pos == 0);
        cur_pos            = sym_pos;
        if (data_mode == 0) begin
          err_sq = fx_sq;
          err_dc = fx_dc;
        end else begin
          err_sq = 18'($urandom_range(0, 262143));
          err_dc = 18'($urandom);
        end
        case (ok_mode)
          0:       rx_data_correct = fx_ok;
          1:       rx_data_correct = !(sym_pos inside {3, 7, 8, 12});
          default: rx_data_correct = ($urandom_range(0, 3) != 0);
        endcase
        sym_pos  = (sym_pos + 1) % PERIOD;
        gap_left = $urandom_range(0, 2);
      end
    end
  end

  always @(posedge sys_clk) begin
    sym_t s;
    cyc_n++;
    if (sym_clk_en === 1'b1) begin
      s.cyc  = cyc_n;
      s.mark = cycle_out_periodic;
      s.sq   = longint'(err_sq);
      s.dc   = longint'($signed(err_dc));
      s.ok   = rx_data_correct;
      s.pos  = cur_pos;
      sym_log.push_back(s);
    end
  end

  int               done_cnt = 0;
  int               done_cyc = 0;
  logic [ACC_W-1:0] cap_sq;
  logic [ACC_W-1:0] cap_dc;
  logic [CNT_W-1:0] cap_sym;
  logic [CNT_W-1:0] cap_err;

  always @(negedge sys_clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc_n;
      cap_sq   = sq_acc;
      cap_dc   = dc_acc;
      cap_sym  = sym_cnt;
      cap_err  = err_cnt;
    end
  end

  // Window = num_periods (0 -> 1) whole periods starting at the first marker
  // after the start-sampling edge c0; the following marker ends it.
  function automatic exp_t model(input int c0, input int p);
    exp_t e;
    int   idx = -1;
    int   n   = ((p == 0) ? 1 : p) * PERIOD;
    e.sq = 0; e.dc = 0; e.sym = 0; e.err = 0; e.term_cyc = -1;
    for (int i = 0; i < sym_log.size(); i++) begin
      if (sym_log[i].cyc > c0 && sym_log[i].mark) begin
        idx = i;
        break;
      end
    end
    if (idx < 0 || idx + n >= sym_log.size()) return e;
    for (int k = 0; k < n; k++) begin
      e.sq = e.sq + sym_log[idx+k].sq;
      if (e.sq > SQ_MAX) e.sq = SQ_MAX;
      e.dc = e.dc + sym_log[idx+k].dc;
      if (e.dc > DC_MAX) e.dc = DC_MAX;
      if (e.dc < DC_MIN) e.dc = DC_MIN;
      e.sym++;
      if (!sym_log[idx+k].ok) e.err++;
    end
    if (sym_log[idx+n].mark) e.term_cyc = sym_log[idx+n].cyc;
    return e;
  endfunction

  task automatic pulse_start(input int p, output int c0);
    @(negedge sys_clk);
    num_periods = 4'(p);
    start       = 1'b1;
    c0          = cyc_n + 1;
    @(negedge sys_clk);
    start       = 1'b0;
  endtask

  task automatic wait_done(input int old, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge sys_clk);
      #1;
      if (done_cnt != old) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge sys_clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if ({sq_acc, dc_acc, sym_cnt, err_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got sq=%0h dc=%0h sym=%0d err=%0d expected all 0", sq_acc, dc_acc, sym_cnt, err_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int c0; bit to; int old; exp_t e;
    data_mode = 0; ok_mode = 0; fx_sq = 18'd100; fx_dc = -18'sd3; fx_ok = 1'b1;
    old = done_cnt;
    pulse_start(2, c0);
    wait_done(old, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout: no done within %0d cycles", BUDGET); return; end
    e = model(c0, 2);
    n_tests++; if (cap_sym !== 32'd30) begin n_fail++; $display("FAIL basic_sym: got %0d expected 30", cap_sym); end
    n_tests++; if (cap_sq !== 20'd3000) begin n_fail++; $display("FAIL basic_sq: got %0d expected 3000", cap_sq); end
    n_tests++; if (cap_dc !== 20'(-90)) begin n_fail++; $display("FAIL basic_dc: got %0d expected -90", $signed(cap_dc)); end
    n_tests++; if (cap_err !== 32'd0) begin n_fail++; $display("FAIL basic_err: got %0d expected 0", cap_err); end
    n_tests++; if (done_cyc != e.term_cyc) begin n_fail++; $display("FAIL basic_done_latency: got cycle %0d expected %0d", done_cyc, e.term_cyc); end
    repeat (5) @(negedge sys_clk);
    #1;
    n_tests++; if (done_cnt != old + 1) begin n_fail++; $display("FAIL basic_done_once: got %0d pulses expected 1", done_cnt - old); end
  endtask

  task automatic test_alignment();
    int c0; int old; int busy_low = 0; bit to = 1'b1; exp_t e;
    data_mode = 1; ok_mode = 2;
    for (int i = 0; i < 200; i++) begin
      @(posedge sys_clk);
      #1;
      if (sym_log.size() > 0 && sym_log[$].pos == 10 && sym_log[$].cyc == cyc_n) break;
    end
    old = done_cnt;
    pulse_start(1, c0);
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge sys_clk);
      #1;
      if (done_cnt != old) begin to = 1'b0; break; end
      if (busy !== 1'b1) busy_low++;
    end
    n_tests++; if (to) begin n_fail++; $display("FAIL align_timeout: no done within %0d cycles", BUDGET); return; end
    e = model(c0, 1);
    n_tests++; if (busy_low != 0) begin n_fail++; $display("FAIL align_busy: busy low on %0d cycles expected 0", busy_low); end
    n_tests++; if (cap_sym !== 32'd15) begin n_fail++; $display("FAIL align_sym: got %0d expected 15", cap_sym); end
    n_tests++; if (cap_sq !== 20'(e.sq)) begin n_fail++; $display("FAIL align_sq: got %0d expected %0d", cap_sq, e.sq); end
    n_tests++; if (cap_dc !== 20'(e.dc)) begin n_fail++; $display("FAIL align_dc: got %0d expected %0d", $signed(cap_dc), e.dc); end
    n_tests++; if (done_cyc != e.term_cyc) begin n_fail++; $display("FAIL align_done_latency: got cycle %0d expected %0d", done_cyc, e.term_cyc); end
  endtask

  task automatic test_zero_periods();
    int c0; bit to; int old; exp_t e;
    data_mode = 1; ok_mode = 1;
    old = done_cnt;
    pulse_start(0, c0);
    wait_done(old, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL zero_timeout: no done within %0d cycles", BUDGET); return; end
    e = model(c0, 0);
    n_tests++; if (cap_sym !== 32'd15) begin n_fail++; $display("FAIL zero_sym: got %0d expected 15", cap_sym); end
    n_tests++; if (cap_err !== 32'd4) begin n_fail++; $display("FAIL zero_err: got %0d expected 4", cap_err); end
    n_tests++; if (cap_sq !== 20'(e.sq)) begin n_fail++; $display("FAIL zero_sq: got %0d expected %0d", cap_sq, e.sq); end
    n_tests++; if (cap_dc !== 20'(e.dc)) begin n_fail++; $display("FAIL zero_dc: got %0d expected %0d", $signed(cap_dc), e.dc); end
  endtask

  task automatic test_saturation();
    int c0; bit to; int old;
    data_mode = 0; ok_mode = 0; fx_sq = 18'd262143; fx_dc = -18'sd131072; fx_ok = 1'b0;
    old = done_cnt;
    pulse_start(1, c0);
    wait_done(old, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL sat_timeout: no done within %0d cycles", BUDGET); return; end
    n_tests++; if (cap_sq !== 20'hFFFFF) begin n_fail++; $display("FAIL sat_sq: got %0d expected 1048575", cap_sq); end
    n_tests++; if (cap_dc !== 20'h80000) begin n_fail++; $display("FAIL sat_dc: got %0d expected -524288", $signed(cap_dc)); end
    n_tests++; if (cap_err !== 32'd15) begin n_fail++; $display("FAIL sat_err: got %0d expected 15", cap_err); end
  endtask

  task automatic test_random();
    int c0; bit to; int old; int p; exp_t e;
    data_mode = 1; ok_mode = 2;
    for (int w = 0; w < 6; w++) begin
      p   = $urandom_range(0, 3);
      old = done_cnt;
      pulse_start(p, c0);
      wait_done(old, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: no done within %0d cycles", w, BUDGET); return; end
      e = model(c0, p);
      n_tests++; if (cap_sym !== 32'(e.sym) || cap_err !== 32'(e.err)) begin
        n_fail++; $display("FAIL rand%0d_counts: got sym=%0d err=%0d expected sym=%0d err=%0d", w, cap_sym, cap_err, e.sym, e.err);
      end
      n_tests++; if (cap_sq !== 20'(e.sq) || cap_dc !== 20'(e.dc)) begin
        n_fail++; $display("FAIL rand%0d_acc: got sq=%0d dc=%0d expected sq=%0d dc=%0d", w, cap_sq, $signed(cap_dc), e.sq, e.dc);
      end
      n_tests++; if (done_cyc != e.term_cyc) begin n_fail++; $display("FAIL rand%0d_done_latency: got cycle %0d expected %0d", w, done_cyc, e.term_cyc); end
    end
  endtask

  task automatic test_back_to_back();
    int c0; bit to; int old; int first_done; exp_t e;
    data_mode = 1; ok_mode = 2;
    @(negedge sys_clk);
    num_periods = 4'd1;
    start       = 1'b1;
    c0          = cyc_n + 1;
    old         = done_cnt;
    wait_done(old, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL b2b_first_timeout: no done within %0d cycles", BUDGET); start = 1'b0; return; end
    first_done = done_cyc;
    e = model(c0, 1);
    n_tests++; if (cap_sq !== 20'(e.sq) || cap_sym !== 32'(e.sym)) begin
      n_fail++; $display("FAIL b2b_first: got sq=%0d sym=%0d expected sq=%0d sym=%0d", cap_sq, cap_sym, e.sq, e.sym);
    end
    @(negedge sys_clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy); end
    @(negedge sys_clk); #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_rearm: got busy=%b expected 1", busy); end
    start = 1'b0;
    old   = done_cnt;
    wait_done(old, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL b2b_second_timeout: no done within %0d cycles", BUDGET); return; end
    e = model(first_done + 2, 1);
    n_tests++; if (cap_sq !== 20'(e.sq) || cap_dc !== 20'(e.dc) || cap_err !== 32'(e.err)) begin
      n_fail++; $display("FAIL b2b_second: got sq=%0d dc=%0d err=%0d expected sq=%0d dc=%0d err=%0d", cap_sq, $signed(cap_dc), cap_err, e.sq, e.dc, e.err);
    end
    n_tests++; if (done_cyc != e.term_cyc) begin n_fail++; $display("FAIL b2b_second_latency: got cycle %0d expected %0d", done_cyc, e.term_cyc); end
  endtask

  task automatic test_busy_start_hold();
    int c0; bit to; int old; exp_t ea; exp_t eb; int held_bad = 0;
    data_mode = 1; ok_mode = 2;
    old = done_cnt;
    pulse_start(1, c0);
    wait_done(old, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL hold_a_timeout: no done within %0d cycles", BUDGET); return; end
    ea  = model(c0, 1);
    old = done_cnt;
    pulse_start(2, c0);
    repeat (50) begin
      @(negedge sys_clk); #1;
      if (sq_acc !== 20'(ea.sq) || dc_acc !== 20'(ea.dc) || sym_cnt !== 32'(ea.sym) || err_cnt !== 32'(ea.err)) held_bad++;
    end
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done(old, to);
    n_tests++; if (held_bad != 0) begin n_fail++; $display("FAIL hold_outputs: changed on %0d cycles before done expected 0", held_bad); end
    n_tests++; if (to) begin n_fail++; $display("FAIL hold_b_timeout: no done within %0d cycles", BUDGET); return; end
    eb = model(c0, 2);
    n_tests++; if (cap_sym !== 32'(eb.sym) || cap_sq !== 20'(eb.sq) || cap_dc !== 20'(eb.dc)) begin
      n_fail++; $display("FAIL busy_start_ignored: got sym=%0d sq=%0d dc=%0d expected sym=%0d sq=%0d dc=%0d", cap_sym, cap_sq, $signed(cap_dc), eb.sym, eb.sq, eb.dc);
    end
    n_tests++; if (done_cyc != eb.term_cyc) begin n_fail++; $display("FAIL busy_start_latency: got cycle %0d expected %0d", done_cyc, eb.term_cyc); end
    repeat (150) @(negedge sys_clk);
    #1;
    n_tests++; if (done_cnt != old + 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_no_rerun: got %0d pulses busy=%b expected 1 pulse busy=0", done_cnt - old, busy);
    end
  endtask

  task automatic test_mid_reset();
    int c0; int old;
    data_mode = 1; ok_mode = 2;
    old = done_cnt;
    pulse_start(2, c0);
    repeat (60) @(negedge sys_clk);
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge sys_clk);
    reset = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got busy=%b done=%b expected 0 0", busy, done); end
    n_tests++; if ({sq_acc, dc_acc, sym_cnt, err_cnt} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got sq=%0d dc=%0d sym=%0d err=%0d expected all 0", sq_acc, $signed(dc_acc), sym_cnt, err_cnt);
    end
    repeat (200) @(negedge sys_clk);
    #1;
    n_tests++; if (done_cnt != old || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_no_done: got %0d pulses busy=%b expected 0 pulses busy=0", done_cnt - old, busy);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_alignment();
    test_zero_periods();
    test_saturation();
    test_random();
    test_back_to_back();
    test_busy_start_hold();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
